hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard responder for the 5-stage core.
- Consumes the controller's stage-tagged write/branch/PC-pending status and register addresses.
- Returns to the controller and datapath:
  - forwarding selects,
  - stall and flush controls, including the FlushE the controller consumes,
  - a multi-cycle divide interlock.
- Contains a small FSM and counter that hold the front of the pipe while UDIV/SDIV executes.

Parameters:
- DIV_CYCLES, 8, total E-stage occupancy of UDIV/SDIV in cycles (legal range 2..64).
- REG_ADDR_WIDTH, 4, register address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RA1D, RA2D  in  REG_ADDR_WIDTH  source registers in D.
- RA1E, RA2E  in  REG_ADDR_WIDTH  source registers in E.
- WA3E, WA3M, WA3W  in  REG_ADDR_WIDTH  destination register per stage.
- RegWriteM, RegWriteW  in  2  write kind: 00 none, 01 32-bit, 11 64-bit (low word to WA3, high word to WA3+1).
- MemtoRegE  in  1  load in E.
- ALUControlE  in  6  ALU op in E; 101110 = UDIV, 101111 = SDIV.
- BranchTakenE  in  1  taken branch resolved in E.
- PCWrPendingF  in  1  PC write in flight in D/E/M.
- PCSrcW  in  1  PC written in W.
- ForwardAE, ForwardBE  out  2  00 regfile, 01 ResultW, 10 ALUOutM low, 11 ALUOutM high.
- StallF, StallD, StallE  out  1  hold stage register.
- FlushD, FlushE, FlushM  out  1  clear stage register (bubble).
- div_busy  out  1  FSM not IDLE.

Behaviour:
- Reset (reset=0, async): FSM=IDLE, div counter=0. All outputs 0 while reset is low; forward selects are combinational but forced to 00 during reset.
- Forwarding (combinational, evaluated per source X ∈ {RA1E, RA2E}). First match wins, in this order:
  - 11: RegWriteM==11 and X==WA3M+1 (mod 2^REG_ADDR_WIDTH).
  - 10: RegWriteM[0] and X==WA3M.
  - 01: RegWriteW[0] and (X==WA3W, or RegWriteW==11 and X==WA3W+1).
  - 00: otherwise.
- Load-use: ldrstall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E). Effect: StallF=StallD=1, FlushE=1.
- Control flow:
  - BranchTakenE: FlushD=1, FlushE=1.
  - PCWrPendingF: StallF=1, FlushD=1.
  - PCSrcW: StallF deasserted by this term; FlushD=1.
- Divide FSM states: IDLE, DIV_BUSY.
  - IDLE → DIV_BUSY when ALUControlE ∈ {UDIV, SDIV} and BranchTakenE=0. Counter loads DIV_CYCLES-2.
  - DIV_BUSY: counter decrements each cycle. Asserts StallF, StallD, StallE and FlushM (bubble into M); drives div_busy=1.
  - DIV_BUSY → IDLE when counter==0 (last stalled cycle). Next cycle the divide advances to M.
  - Total E occupancy is exactly DIV_CYCLES cycles. The FSM does not re-trigger on the same instruction because the exit cycle drops the stalls and E advances.
  - Combinational start term: in the IDLE cycle where a divide is first seen in E, StallF/D/E and FlushM are already 1 (div_start term).
- Priority (simultaneous events):
  - Divide stall dominates, but FlushD/FlushE from BranchTakenE or PCSrcW are suppressed while div stall is active.
  - The divide is in E, so ldrstall and BranchTakenE cannot legally coincide with it.
  - ldrstall together with BranchTakenE: FlushE=1 and FlushD=1. StallD is masked by BranchTakenE so D takes the bubble.
- Reset mid-divide: FSM returns to IDLE immediately and all stalls drop.

Optional Feature:
- HAZARD_PERF_CNT_EN, when defined, adds:
  - Outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments on every cycle with StallF=1.
  - flush_events increments on every cycle with FlushD|FlushE=1.
  - Both counters are cleared by reset and wrap at 2^32.
- When undefined: no such ports or counter logic exist.

Test Plan:
- Forwarding: RegWriteM=01, WA3M=3, RA1E=3, while W also writes reg 3 → ForwardAE=10. M-stage priority over W is verified.
- 64-bit forwarding:
  - RegWriteM=11, WA3M=4, RA2E=5 → ForwardBE=11.
  - Same with WA3M=15 and RA2E=0 (wrap) → ForwardBE=11.
- Load-use: MemtoRegE=1, WA3E=2, RA2D=2 → StallF=StallD=FlushE=1 for exactly one cycle, then all 0.
- Divide, DIV_CYCLES=8: ALUControlE=101110 enters E.
  - StallF/D/E=1 for 7 consecutive cycles; div_busy=1 for 6.
  - Cycle 8: all stalls 0.
  - FlushM=1 during the 7 stalled cycles.
- Branch, then PC write:
  - BranchTakenE=1 → FlushD=FlushE=1 that cycle.
  - PCWrPendingF=1 for 3 cycles → StallF=FlushD=1 for those 3 cycles.
- Reset mid-divide: assert reset=0 at busy cycle 3 → div_busy and all stalls 0 immediately (asynchronously). After release, FSM is IDLE.

Source files
------------

// File: rtl/hazard_if.sv
// Controller <-> hazard unit status and control bundle for the 5-stage core.
// slave = hazard unit side, master = controller/datapath side.
interface hazard_if #(
  parameter int REG_ADDR_WIDTH = 4
);
  logic [REG_ADDR_WIDTH-1:0] RA1D;
  logic [REG_ADDR_WIDTH-1:0] RA2D;
  logic [REG_ADDR_WIDTH-1:0] RA1E;
  logic [REG_ADDR_WIDTH-1:0] RA2E;
  logic [REG_ADDR_WIDTH-1:0] WA3E;
  logic [REG_ADDR_WIDTH-1:0] WA3M;
  logic [REG_ADDR_WIDTH-1:0] WA3W;
  logic [1:0]                RegWriteM;
  logic [1:0]                RegWriteW;
  logic                      MemtoRegE;
  logic [5:0]                ALUControlE;
  logic                      BranchTakenE;
  logic                      PCWrPendingF;
  logic                      PCSrcW;

  logic [1:0]                ForwardAE;
  logic [1:0]                ForwardBE;
  logic                      StallF;
  logic                      StallD;
  logic                      StallE;
  logic                      FlushD;
  logic                      FlushE;
  logic                      FlushM;
  logic                      div_busy;

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteM, RegWriteW, MemtoRegE, ALUControlE,
    input  BranchTakenE, PCWrPendingF, PCSrcW,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, div_busy
  );

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteM, RegWriteW, MemtoRegE, ALUControlE,
    output BranchTakenE, PCWrPendingF, PCSrcW,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, div_busy
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use/control-flow stalls and flushes, divide interlock.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_events performance counters.
module hazard_unit #(
  parameter int DIV_CYCLES     = 8,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  hazard_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam int                CNT_W     = 6;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(DIV_CYCLES - 2);
  localparam bit                SHORT_DIV = (DIV_CYCLES == 2);
  localparam logic [5:0]        ALU_UDIV  = 6'b101110;
  localparam logic [5:0]        ALU_SDIV  = 6'b101111;

  typedef enum logic {
    IDLE,
    DIV_BUSY
  } div_state_e;

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_last_q, div_last_d;

  logic              div_op;
  logic              div_start;
  logic              div_stall;
  logic              ldrstall;

  // Forward select for one E-stage source; the M-stage high word wins over everything.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] src,
    input logic [REG_ADDR_WIDTH-1:0] wa3m,
    input logic [REG_ADDR_WIDTH-1:0] wa3w,
    input logic [1:0]                rwm,
    input logic [1:0]                rww
  );
    logic [REG_ADDR_WIDTH-1:0] wa3m_hi;
    logic [REG_ADDR_WIDTH-1:0] wa3w_hi;
    wa3m_hi = wa3m + 1'b1;
    wa3w_hi = wa3w + 1'b1;
    if (rwm == 2'b11 && src == wa3m_hi)
      fwd_sel = 2'b11;
    else if (rwm[0] && src == wa3m)
      fwd_sel = 2'b10;
    else if (rww[0] && (src == wa3w || (rww == 2'b11 && src == wa3w_hi)))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  // div_last_q blocks a second start on the cycle the finished divide leaves E.
  assign div_op    = (hz.ALUControlE == ALU_UDIV) || (hz.ALUControlE == ALU_SDIV);
  assign div_start = (state_q == IDLE) && div_op && !hz.BranchTakenE && !div_last_q;
  assign div_stall = div_start || (state_q == DIV_BUSY);
  assign ldrstall  = hz.MemtoRegE && ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_last_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_start) begin
          if (SHORT_DIV) begin
            div_last_d = 1'b1;
          end else begin
            state_d = DIV_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      DIV_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = IDLE;
          div_last_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_last_q <= div_last_d;
    end
  end

  // Every output is forced low while reset is held, including the combinational terms.
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.div_busy  = 1'b0;
    if (reset) begin
      hz.ForwardAE = fwd_sel(hz.RA1E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW);
      hz.ForwardBE = fwd_sel(hz.RA2E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW);
      hz.StallF    = div_stall || ((ldrstall || hz.PCWrPendingF) && !hz.PCSrcW);
      hz.StallD    = div_stall || (ldrstall && !hz.BranchTakenE);
      hz.StallE    = div_stall;
      hz.FlushD    = hz.PCWrPendingF || (!div_stall && (hz.BranchTakenE || hz.PCSrcW));
      hz.FlushE    = ldrstall || (!div_stall && hz.BranchTakenE);
      hz.FlushM    = div_stall;
      hz.div_busy  = (state_q == DIV_BUSY);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (hz.StallF)
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (hz.FlushD || hz.FlushE)
      flush_events_d = flush_events_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (DIV_CYCLES=8): forwarding, load-use, divide interlock,
// control-flow flushes and asynchronous reset in the middle of a divide.
module tb_hazard_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  hazard_if #(.REG_ADDR_WIDTH(4)) hif ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  hazard_unit #(
    .DIV_CYCLES     (8),
    .REG_ADDR_WIDTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hz           (hif.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic clearInputs();
    hif.RA1D         = 4'd0;
    hif.RA2D         = 4'd0;
    hif.RA1E         = 4'd0;
    hif.RA2E         = 4'd0;
    hif.WA3E         = 4'd9;
    hif.WA3M         = 4'd0;
    hif.WA3W         = 4'd0;
    hif.RegWriteM    = 2'b00;
    hif.RegWriteW    = 2'b00;
    hif.MemtoRegE    = 1'b0;
    hif.ALUControlE  = 6'b000000;
    hif.BranchTakenE = 1'b0;
    hif.PCWrPendingF = 1'b0;
    hif.PCSrcW       = 1'b0;
  endtask

  // Advance one clock and leave time for inputs to be driven away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Compact check of the stall/flush/busy outputs as {F,D,E} stalls and {D,E,M} flushes.
  task automatic checkCtrl(input string tag, input logic [2:0] stalls, input logic [2:0] flushes,
                           input logic busy);
    #1;
    checkOutput({tag, ".StallF"},   {1'b0, hif.StallF},   {1'b0, stalls[2]});
    checkOutput({tag, ".StallD"},   {1'b0, hif.StallD},   {1'b0, stalls[1]});
    checkOutput({tag, ".StallE"},   {1'b0, hif.StallE},   {1'b0, stalls[0]});
    checkOutput({tag, ".FlushD"},   {1'b0, hif.FlushD},   {1'b0, flushes[2]});
    checkOutput({tag, ".FlushE"},   {1'b0, hif.FlushE},   {1'b0, flushes[1]});
    checkOutput({tag, ".FlushM"},   {1'b0, hif.FlushM},   {1'b0, flushes[0]});
    checkOutput({tag, ".div_busy"}, {1'b0, hif.div_busy}, {1'b0, busy});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    clearInputs();
    // Hazard-provoking inputs while in reset must not reach any output.
    hif.RegWriteM   = 2'b01;
    hif.WA3M        = 4'd3;
    hif.RA1E        = 4'd3;
    hif.MemtoRegE   = 1'b1;
    hif.WA3E        = 4'd2;
    hif.RA2D        = 4'd2;
    hif.ALUControlE = 6'b101110;
    #2;
    checkOutput("rst.ForwardAE", hif.ForwardAE, 2'b00);
    checkCtrl("rst", 3'b000, 3'b000, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    clearInputs();

    // M-stage 32-bit write beats W writing the same register.
    applyStimulus();
    hif.RegWriteM = 2'b01; hif.WA3M = 4'd3; hif.RA1E = 4'd3;
    hif.RegWriteW = 2'b01; hif.WA3W = 4'd3; hif.RA2E = 4'd7;
    #1;
    checkOutput("fwd.M_over_W", hif.ForwardAE, 2'b10);
    checkOutput("fwd.nomatch",  hif.ForwardBE, 2'b00);
    hif.RegWriteM = 2'b00;
    #1;
    checkOutput("fwd.W32", hif.ForwardAE, 2'b01);
    hif.RegWriteW = 2'b11; hif.WA3W = 4'd6; hif.RA2E = 4'd7;
    #1;
    checkOutput("fwd.W64hi", hif.ForwardBE, 2'b01);

    // 64-bit M write: high word to WA3M+1, including wrap 15 -> 0.
    hif.RegWriteW = 2'b00;
    hif.RegWriteM = 2'b11; hif.WA3M = 4'd4; hif.RA2E = 4'd5; hif.RA1E = 4'd4;
    #1;
    checkOutput("fwd.M64hi", hif.ForwardBE, 2'b11);
    checkOutput("fwd.M64lo", hif.ForwardAE, 2'b10);
    hif.WA3M = 4'd15; hif.RA2E = 4'd0;
    #1;
    checkOutput("fwd.M64wrap", hif.ForwardBE, 2'b11);

    // Load-use hazard for one cycle.
    applyStimulus();
    clearInputs();
    hif.MemtoRegE = 1'b1; hif.WA3E = 4'd2; hif.RA2D = 4'd2;
    checkCtrl("ldr", 3'b110, 3'b010, 1'b0);
    applyStimulus();
    clearInputs();
    checkCtrl("ldr.after", 3'b000, 3'b000, 1'b0);

    // UDIV held in E: 1 start cycle + 6 busy cycles stalled, then released.
    applyStimulus();
    hif.ALUControlE = 6'b101110;
    checkCtrl("div.c0", 3'b111, 3'b001, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus();
      checkCtrl($sformatf("div.c%0d", i), 3'b111, 3'b001, 1'b1);
    end
    applyStimulus();
    checkCtrl("div.c7", 3'b000, 3'b000, 1'b0);
    applyStimulus();
    clearInputs();
    checkCtrl("div.c8", 3'b000, 3'b000, 1'b0);

    // Taken branch, then branch colliding with a load-use stall.
    applyStimulus();
    hif.BranchTakenE = 1'b1;
    checkCtrl("br", 3'b000, 3'b110, 1'b0);
    hif.MemtoRegE = 1'b1; hif.WA3E = 4'd2; hif.RA1D = 4'd2;
    checkCtrl("br.ldr", 3'b100, 3'b110, 1'b0);
    // A divide does not start in E when the branch kills it.
    hif.MemtoRegE = 1'b0; hif.ALUControlE = 6'b101111;
    checkCtrl("br.div", 3'b000, 3'b110, 1'b0);
    applyStimulus();
    clearInputs();
    checkCtrl("br.after", 3'b000, 3'b000, 1'b0);

    // PC write in flight for three cycles, then PC written in W.
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      hif.PCWrPendingF = 1'b1;
      checkCtrl($sformatf("pcwr%0d", i), 3'b100, 3'b100, 1'b0);
    end
    applyStimulus();
    hif.PCWrPendingF = 1'b0;
    hif.PCSrcW       = 1'b1;
    checkCtrl("pcsrcw", 3'b000, 3'b100, 1'b0);
    applyStimulus();
    clearInputs();
    checkCtrl("pc.after", 3'b000, 3'b000, 1'b0);

    // Reset asserted asynchronously during busy cycle 3 of a divide.
    applyStimulus();
    hif.ALUControlE = 6'b101110;
    for (int i = 1; i <= 3; i++) applyStimulus();
    checkCtrl("rdiv.c3", 3'b111, 3'b001, 1'b1);
    reset = 1'b0;
    checkCtrl("rdiv.async", 3'b000, 3'b000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    clearInputs();
    applyStimulus();
    checkCtrl("rdiv.idle", 3'b000, 3'b000, 1'b0);
    // FSM must be back in IDLE: a fresh SDIV starts normally.
    hif.ALUControlE = 6'b101111;
    checkCtrl("rdiv.restart", 3'b111, 3'b001, 1'b0);
    applyStimulus();
    checkCtrl("rdiv.busy", 3'b111, 3'b001, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
